ldpc12_syndrome_check: RTL and testbench

Receive-side counterpart of the 12-block quasi-cyclic parity encoder. It accepts a serial hard-decision codeword of N = 4680 bits (4320 information bits followed by 360 parity bits, in encoder output order). It recomputes the parity from the information bits using the same G_rom12 generator rows, folds in the received parity, and reports whether the 360-bit syndrome is zero. Optionally it also reports the syndrome Hamming weight. It sits after the demapper and before the information-bit sink, as a frame-validity flag.

---
 rtl/ldpc12_pkg.sv | 30 +++
 rtl/G_rom12.sv | 22 ++
 rtl/ldpc12_weight_acc.sv | 23 ++
 rtl/ldpc12_syndrome_check.sv | 159 +++++++++++++++
 tb/tb_ldpc12_syndrome_check.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ldpc12_pkg.sv
// Shared constants, state encoding and helpers for the 12-block QC syndrome checker.
package ldpc12_pkg;

   localparam int K      = 4320;
   localparam int M      = 360;
   localparam int NBLK   = 12;
   localparam int N      = 4680;
   localparam int WBYTES = 45;

   localparam logic [8:0] ROW_PRE = 9'd357;
   localparam logic [8:0] P_LAST  = 9'(M - 1);
   localparam logic [8:0] W_LAST  = 9'(WBYTES - 1);
   localparam logic [3:0] B_LAST  = 4'(NBLK - 1);

   typedef enum logic [2:0] {
      IDLE,
      INFO,
      PARITY,
      WEIGHT,
      DONE
   } state_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/G_rom12.sv
// Generator-row ROM for the 12-block QC code: 4-bit address, 360-bit row, one-cycle read latency.
module G_rom12 (
   input  logic         clka,
   input  logic [3:0]   addra,
   output logic [359:0] douta
);

   // Row contents come from a fixed multiplicative hash of (row, bit).
   function automatic logic [359:0] gen_row(input logic [3:0] blk);
      logic [31:0] h;
      gen_row = '0;
      for (int i = 0; i < 360; i++) begin
         h          = 32'(i) * 32'h9E37_79B1 + 32'(blk) * 32'd40503;
         gen_row[i] = h[17];
      end
   endfunction

   always_ff @(posedge clka) begin
      douta <= (addra < 4'd12) ? gen_row(addra) : '0;
   end

endmodule

// File: rtl/ldpc12_weight_acc.sv
// Byte popcount added into a 9-bit accumulator; total is the running sum including the current byte.
module ldpc12_weight_acc
   import ldpc12_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] byte_in,
   output logic [8:0] total
);

   logic [8:0] acc;

   assign total = acc + {5'b00000, popcount8(byte_in)};

   always_ff @(posedge clk) begin
      if (!rst_n)   acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= total;
   end

endmodule

// File: rtl/ldpc12_syndrome_check.sv
// Serial QC-LDPC syndrome checker: re-encodes the info bits, folds in received parity, flags zero syndrome.
// Define ERR_WEIGHT_EN to build the syndrome popcount (WEIGHT state); otherwise err_weight is tied to 0.
module ldpc12_syndrome_check
   import ldpc12_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sof,
   input  logic       din_valid,
   input  logic       din,
   output logic       in_ready,
   output logic       done,
   output logic       syndrome_ok,
   output logic [8:0] err_weight
);

   state_t         state;
   logic [8:0]     p;
   logic [3:0]     b;
   logic [3:0]     rom_addr;
   logic [M-1:0]   rom_out;
   logic [M-1:0]   row_reg;
   logic [M-1:0]   row0;
   logic [M-1:0]   syndrome;
   logic [M-1:0]   syn_nxt;
   logic [8:0]     par_idx;
   logic           accept;
   logic           start;

   assign accept  = din_valid & in_ready;
   assign start   = accept & sof;
   assign par_idx = P_LAST - p;

   G_rom12 u_rom (
      .clka  (clk),
      .addra (rom_addr),
      .douta (rom_out)
   );

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      syn_nxt = syndrome;
      if (start) begin
         syn_nxt = din ? row0 : '0;
      end else if (state == INFO) begin
         if (din) syn_nxt = syndrome ^ row_reg;
      end else if (state == PARITY) begin
         syn_nxt[par_idx] = syndrome[par_idx] ^ din;
      end
   end

   // NOTE: wide data rows carry no reset; they are always reloaded from the ROM before use.
   always_ff @(posedge clk) begin
      if (state == IDLE) row0 <= rom_out;
      if (start)
         row_reg <= {row0[0], row0[M-1:1]};
      else if (state == IDLE)
         row_reg <= rom_out;
      else if (accept && state == INFO)
         row_reg <= (p == P_LAST) ? rom_out : {row_reg[0], row_reg[M-1:1]};
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         p           <= '0;
         b           <= '0;
         rom_addr    <= '0;
         syndrome    <= '0;
         in_ready    <= 1'b1;
         done        <= 1'b0;
         syndrome_ok <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // sof restarts from bit 0 in any accepting state, aborting a frame in flight
            syndrome <= syn_nxt;
            state    <= INFO;
            p        <= 9'd1;
            b        <= '0;
            rom_addr <= '0;
         end else begin
            case (state)
               IDLE: ;
               INFO: if (accept) begin
                  syndrome <= syn_nxt;
                  if (p == ROW_PRE) rom_addr <= (b == B_LAST) ? 4'd0 : b + 4'd1;
                  if (p == P_LAST) begin
                     p <= '0;
                     if (b == B_LAST) begin
                        b     <= '0;
                        state <= PARITY;
                     end else begin
                        b <= b + 4'd1;
                     end
                  end else begin
                     p <= p + 9'd1;
                  end
               end
               PARITY: if (accept) begin
                  syndrome <= syn_nxt;
                  if (p == P_LAST) begin
                     p           <= '0;
                     syndrome_ok <= (syn_nxt == '0);
                     in_ready    <= 1'b0;
`ifdef ERR_WEIGHT_EN
                     state       <= WEIGHT;
`else
                     state       <= DONE;
                     done        <= 1'b1;
`endif
                  end else begin
                     p <= p + 9'd1;
                  end
               end
               WEIGHT: begin
                  if (p == W_LAST) begin
                     p     <= '0;
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     p <= p + 9'd1;
                  end
               end
               DONE: begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef ERR_WEIGHT_EN
   logic [8:0] acc_total;

   ldpc12_weight_acc u_wacc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state != WEIGHT),
      .en      (state == WEIGHT),
      .byte_in (syndrome[{p[5:0], 3'b000} +: 8]),
      .total   (acc_total)
   );

   // Capture on the last byte so the weight is already valid alongside done.
   always_ff @(posedge clk) begin
      if (!rst_n)
         err_weight <= '0;
      else if (state == WEIGHT && p == W_LAST)
         err_weight <= acc_total;
   end
`else
   assign err_weight = '0;
`endif

endmodule

// File: tb/tb_ldpc12_syndrome_check.sv
// Directed bench for ldpc12_syndrome_check; honours ERR_WEIGHT_EN for latency and weight expectations.
module tb_ldpc12_syndrome_check;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sof = 1'b0;
   logic       din_valid = 1'b0;
   logic       din = 1'b0;
   logic       in_ready;
   logic       done;
   logic       syndrome_ok;
   logic [8:0] err_weight;

`ifdef ERR_WEIGHT_EN
   localparam int LAT  = 46;
   localparam bit W_EN = 1'b1;
`else
   localparam int LAT  = 1;
   localparam bit W_EN = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int done_count = 0;
   int dc;

   bit frame   [4680];
   bit frame_d [4680];
   bit frame_u [4680];
   bit par_ref [360];

   ldpc12_syndrome_check dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sof         (sof),
      .din_valid   (din_valid),
      .din         (din),
      .in_ready    (in_ready),
      .done        (done),
      .syndrome_ok (syndrome_ok),
      .err_weight  (err_weight)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done === 1'b1) done_count++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Generator bit G[blk][i] of the reference code.
   function automatic bit g_bit(input int blk, input int i);
      int unsigned h;
      h = i * 32'h9E3779B1 + blk * 40503;
      return h[17];
   endfunction

   // Reference encoder: info bit at (b,p) contributes G[b][(i+p) mod 360] to parity bit i.
   task automatic encode();
      for (int i = 0; i < 360; i++) par_ref[i] = 1'b0;
      for (int c = 0; c < 4320; c++)
         if (frame[c])
            for (int i = 0; i < 360; i++)
               par_ref[i] ^= g_bit(c / 360, (i + c % 360) % 360);
      for (int k = 0; k < 360; k++) frame[4320 + k] = par_ref[359 - k];
   endtask

   task automatic clear_frame();
      for (int c = 0; c < 4680; c++) frame[c] = 1'b0;
   endtask

   task automatic send_bit(input bit s, input bit d, input bit gaps);
      if (gaps)
         for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) tick();
      din_valid = 1'b1;
      sof       = s;
      din       = d;
      tick();
      din_valid = 1'b0;
      sof       = 1'b0;
   endtask

   task automatic send_range(input int from, input int to, input bit gaps);
      for (int c = from; c <= to; c++) send_bit(c == 0, frame[c], gaps);
   endtask

   // Called in the cycle after the last parity bit was accepted.
   task automatic finish_frame(input string tag, input bit exp_ok, input int exp_w, input bit poke);
      int waited;
      check({tag, "_ready_low"}, 32'(in_ready), 0);
      if (poke) begin
         din_valid = 1'b1;
         sof       = 1'b1;
         din       = 1'b1;
      end
      waited = 0;
      while (done !== 1'b1 && waited < LAT + 5) begin
         tick();
         waited++;
      end
      check({tag, "_latency"}, waited + 1, LAT);
      check({tag, "_ok"}, 32'(syndrome_ok), 32'(exp_ok));
      check({tag, "_weight"}, 32'(err_weight), W_EN ? exp_w : 0);
      tick();
      din_valid = 1'b0;
      sof       = 1'b0;
      din       = 1'b0;
      check({tag, "_done_pulse"}, 32'(done), 0);
      check({tag, "_ready_high"}, 32'(in_ready), 1);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_done", 32'(done), 0);
      check("rst_syndrome_ok", 32'(syndrome_ok), 0);
      check("rst_err_weight", 32'(err_weight), 0);
      rst_n = 1'b1;
      repeat (3) tick();

      // All-zero codeword; bits offered while in_ready is low must be dropped.
      clear_frame();
      send_range(0, 4679, 1'b0);
      finish_frame("zero", 1'b1, 0, 1'b1);

      // Single info bit 0: parity is G[0] sent MSB first.
      clear_frame();
      frame[0] = 1'b1;
      for (int k = 0; k < 360; k++) frame[4320 + k] = g_bit(0, 359 - k);
      frame_u = frame;
      send_range(0, 4679, 1'b0);
      finish_frame("unit", 1'b1, 0, 1'b0);

      frame[4320 + 5] ^= 1'b1;
      send_range(0, 4679, 1'b0);
      finish_frame("flip5", 1'b0, 1, 1'b0);

      // Random info through the reference encoder with three parity flips.
      clear_frame();
      for (int c = 0; c < 4320; c++) frame[c] = 1'($urandom_range(0, 1));
      encode();
      frame[4320 + $urandom_range(0, 119)]   ^= 1'b1;
      frame[4320 + $urandom_range(120, 239)] ^= 1'b1;
      frame[4320 + $urandom_range(240, 359)] ^= 1'b1;
      frame_d = frame;
      send_range(0, 4679, 1'b0);
      finish_frame("rand3", 1'b0, 3, 1'b0);

      // Abort at c=2000 with a new sof, then a clean all-zero frame.
      dc = done_count;
      send_range(0, 1999, 1'b0);
      clear_frame();
      send_range(0, 4679, 1'b0);
      finish_frame("abort", 1'b1, 0, 1'b0);
      check("abort_done_count", done_count - dc, 1);

      // Gapped partial frame cut by reset, then gapped full frames.
      dc = done_count;
      frame = frame_d;
      send_range(0, 999, 1'b1);
      rst_n = 1'b0;
      tick();
      tick();
      check("midrst_syndrome_ok", 32'(syndrome_ok), 0);
      check("midrst_in_ready", 32'(in_ready), 1);
      check("midrst_done", 32'(done), 0);
      rst_n = 1'b1;
      tick();
      tick();
      frame = frame_u;
      send_range(0, 4679, 1'b1);
      finish_frame("gap_unit", 1'b1, 0, 1'b0);
      check("gap_done_count", done_count - dc, 1);

      frame = frame_d;
      send_range(0, 4679, 1'b1);
      finish_frame("gap_rand3", 1'b0, 3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
